// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | trap_ctrl_pkg : CSR addresses, mcause bits and trap FSM encoding    |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  localparam logic [31:0] MCAUSE_IRQ_BIT = 32'h8000_0000;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_W_MEPC     = 3'd1;
  localparam logic [2:0] ST_W_MCAUSE   = 3'd2;
  localparam logic [2:0] ST_W_MTVAL    = 3'd3;
  localparam logic [2:0] ST_TRAP_REDIR = 3'd4;
  localparam logic [2:0] ST_MRET_REDIR = 3'd5;

  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_target.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | trap_target : handler address from mtvec (TRAP_VECTORED_EN adds     |
// |               vectored interrupt mode)                              |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
module trap_target
  import trap_ctrl_pkg::*;
(
  input  logic [31:0] mtvec,
  input  logic [4:0]  cap_cause,
  input  logic        cap_irq,
  output logic [31:0] handler
);

`ifdef TRAP_VECTORED_EN
  // Only mode 01 with an interrupt is vectored; 10/11 fall back to direct.
  always_comb begin
    handler = align4(mtvec);
    if ((mtvec[1:0] == 2'b01) && cap_irq)
      handler = align4(mtvec) + {25'b0, cap_cause, 2'b00};
  end
`else
  logic unused_mode;
  assign unused_mode = &{1'b0, mtvec[1:0], cap_cause, cap_irq};

  always_comb begin
    handler = align4(mtvec);
  end
`endif

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | trap_ctrl : M-mode trap sequencer (mepc/mcause/mtval writes, fetch  |
// |             redirect, mret). Option: TRAP_VECTORED_EN               |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [30:0] IRQ_CAUSE = 31'd11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_tval,
  input  logic [31:0] pc,
  input  logic        irq_pending,
  input  logic        irq_enable,
  input  logic        mret_valid,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        busy,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        mstatus_trap,
  output logic        mstatus_mret,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  logic [2:0]  state_q, state_d;
  logic [29:0] cap_pc_q, cap_pc_d;
  logic [31:0] cap_cause_q, cap_cause_d;
  logic [31:0] cap_tval_q, cap_tval_d;
  logic        cap_irq_q, cap_irq_d;
  logic [31:0] handler;

  logic unused_lsb;
  assign unused_lsb = &{1'b0, pc[1:0]};

  always_comb begin
    state_d     = state_q;
    cap_pc_d    = cap_pc_q;
    cap_cause_d = cap_cause_q;
    cap_tval_d  = cap_tval_q;
    cap_irq_d   = cap_irq_q;
    case (state_q)
      ST_IDLE: begin
        if (exc_valid) begin
          state_d     = ST_W_MEPC;
          cap_pc_d    = pc[31:2];
          cap_cause_d = {27'b0, exc_cause};
          cap_tval_d  = exc_tval;
          cap_irq_d   = 1'b0;
        end else if (irq_pending && irq_enable) begin
          state_d     = ST_W_MEPC;
          cap_pc_d    = pc[31:2];
          cap_cause_d = MCAUSE_IRQ_BIT | {1'b0, IRQ_CAUSE};
          cap_tval_d  = 32'h0;
          cap_irq_d   = 1'b1;
        end else if (mret_valid) begin
          state_d = ST_MRET_REDIR;
        end
      end
      ST_W_MEPC:     state_d = ST_W_MCAUSE;
      ST_W_MCAUSE:   state_d = ST_W_MTVAL;
      ST_W_MTVAL:    state_d = ST_TRAP_REDIR;
      ST_TRAP_REDIR: state_d = ST_IDLE;
      ST_MRET_REDIR: state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cap_pc_q    <= '0;
      cap_cause_q <= '0;
      cap_tval_q  <= '0;
      cap_irq_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_pc_q    <= cap_pc_d;
      cap_cause_q <= cap_cause_d;
      cap_tval_q  <= cap_tval_d;
      cap_irq_q   <= cap_irq_d;
    end
  end

  trap_target u_trap_target (
    .mtvec     (mtvec),
    .cap_cause (cap_cause_q[4:0]),
    .cap_irq   (cap_irq_q),
    .handler   (handler)
  );

  // Moore decode: mtvec/mepc are read live in the redirect states on purpose.
  always_comb begin
    busy           = (state_q != ST_IDLE);
    csr_we         = 1'b0;
    csr_waddr      = 12'h0;
    csr_wdata      = 32'h0;
    mstatus_trap   = 1'b0;
    mstatus_mret   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    case (state_q)
      ST_W_MEPC: begin
        csr_we       = 1'b1;
        csr_waddr    = CSR_MEPC;
        csr_wdata    = {cap_pc_q, 2'b00};
        mstatus_trap = 1'b1;
      end
      ST_W_MCAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = cap_cause_q;
      end
      ST_W_MTVAL: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = cap_tval_q;
      end
      ST_TRAP_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = handler;
      end
      ST_MRET_REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = align4(mepc);
        mstatus_mret   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_trap_ctrl : directed + random bench with a queue-based model     |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, exc_valid, irq_pending, irq_enable, mret_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_tval, pc, mtvec, mepc;
  logic        busy, csr_we, mstatus_trap, mstatus_mret, redirect_valid;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata, redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_tval       (exc_tval),
    .pc             (pc),
    .irq_pending    (irq_pending),
    .irq_enable     (irq_enable),
    .mret_valid     (mret_valid),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .busy           (busy),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .mstatus_trap   (mstatus_trap),
    .mstatus_mret   (mstatus_mret),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  // One record per expected busy cycle; kind 1 = trap redirect, 2 = mret redirect.
  typedef struct {
    bit        busy;
    bit        we;
    bit [11:0] addr;
    bit [31:0] data;
    bit        trap;
    bit        mret;
    bit        redir;
    int        kind;
    bit        irq;
    bit [4:0]  cause;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  function automatic exp_t idle_rec();
    exp_t r;
    r = '{default: 0};
    return r;
  endfunction

  task automatic push_trap(input bit [31:0] p, input bit [31:0] cause,
                           input bit [31:0] tval, input bit irq);
    exp_t r;
    r = idle_rec(); r.busy = 1; r.we = 1; r.addr = 12'h341; r.data = p & ~32'h3; r.trap = 1;
    q.push_back(r);
    r = idle_rec(); r.busy = 1; r.we = 1; r.addr = 12'h342; r.data = cause;
    q.push_back(r);
    r = idle_rec(); r.busy = 1; r.we = 1; r.addr = 12'h343; r.data = tval;
    q.push_back(r);
    r = idle_rec(); r.busy = 1; r.redir = 1; r.kind = 1; r.irq = irq; r.cause = cause[4:0];
    q.push_back(r);
  endtask

  task automatic model_edge();
    exp_t r;
    if (!rst_n) begin
      q.delete();
      cur = idle_rec();
    end else begin
      if (!cur.busy) begin
        if (exc_valid)
          push_trap(pc, {27'b0, exc_cause}, exc_tval, 1'b0);
        else if (irq_pending && irq_enable)
          push_trap(pc, 32'h8000_0000 + 32'd11, 32'h0, 1'b1);
        else if (mret_valid) begin
          r = idle_rec(); r.busy = 1; r.redir = 1; r.mret = 1; r.kind = 2;
          q.push_back(r);
        end
      end
      cur = (q.size() > 0) ? q.pop_front() : idle_rec();
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    if (cur.kind == 1) begin
      exp_pc = mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
      if (mtvec[1:0] == 2'b01 && cur.irq) exp_pc = exp_pc + 32'(cur.cause) * 4;
`endif
    end else if (cur.kind == 2) begin
      exp_pc = mepc & ~32'h3;
    end
    chk("busy",           32'(busy),           32'(cur.busy));
    chk("csr_we",         32'(csr_we),         32'(cur.we));
    chk("csr_waddr",      32'(csr_waddr),      32'(cur.addr));
    chk("csr_wdata",      csr_wdata,           cur.data);
    chk("mstatus_trap",   32'(mstatus_trap),   32'(cur.trap));
    chk("mstatus_mret",   32'(mstatus_mret),   32'(cur.mret));
    chk("redirect_valid", 32'(redirect_valid), 32'(cur.redir));
    chk("redirect_pc",    redirect_pc,         exp_pc);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic quiet();
    exc_valid = 0; irq_pending = 0; irq_enable = 0; mret_valid = 0;
  endtask

  initial begin
    cur = idle_rec();
    rst_n = 0; quiet(); exc_cause = 0; exc_tval = 0; pc = 0; mtvec = 0; mepc = 0;
    @(negedge clk);

    // reset held with a pending exception
    exc_valid = 1;
    cycle(); cycle();
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1; exc_valid = 0;
    cycle();

    // exception
    exc_valid = 1; exc_cause = 5'd2; pc = 32'h0000_1004; exc_tval = 32'hDEAD_BEEF;
    mtvec = 32'h0000_0100;
    cycle(); exc_valid = 0;
    chk("exc_mepc", csr_wdata, 32'h0000_1004);
    chk("exc_trap_pulse", 32'(mstatus_trap), 32'h1);
    cycle(); chk("exc_mcause", csr_wdata, 32'h2);
    cycle(); chk("exc_mtval", csr_wdata, 32'hDEAD_BEEF);
    cycle(); chk("exc_redir", redirect_pc, 32'h0000_0100);
    cycle(); chk("exc_done", 32'(busy), 32'h0);

    // interrupt, vectored-capable mtvec
    irq_pending = 1; irq_enable = 1; pc = 32'h2000; mtvec = 32'h0000_0201;
    cycle(); quiet();
    cycle(); chk("irq_mcause", csr_wdata, 32'h8000_000B);
    cycle(); chk("irq_mtval", csr_wdata, 32'h0);
    cycle();
`ifdef TRAP_VECTORED_EN
    chk("irq_redir", redirect_pc, 32'h0000_022C);
`else
    chk("irq_redir", redirect_pc, 32'h0000_0200);
`endif
    cycle();
    irq_pending = 1; irq_enable = 0;
    cycle(); cycle(); chk("irq_masked", 32'(busy), 32'h0);
    quiet();

    // priority and busy-ignore
    exc_valid = 1; irq_pending = 1; irq_enable = 1; mret_valid = 1; exc_cause = 5'd7;
    cycle(); quiet();
    exc_valid = 1; exc_cause = 5'd3;
    cycle(); exc_valid = 0;
    chk("prio_mcause", csr_wdata, 32'h7);
    cycle(); cycle(); cycle();
    cycle(); chk("prio_no_retrap", 32'(busy), 32'h0);

    // mret
    mret_valid = 1; mepc = 32'h0000_3006;
    cycle(); mret_valid = 0;
    chk("mret_pc", redirect_pc, 32'h0000_3004);
    chk("mret_pulse", 32'(mstatus_mret), 32'h1);
    chk("mret_we", 32'(csr_we), 32'h0);
    cycle(); chk("mret_done", 32'(busy), 32'h0);

    // reset during W_MCAUSE
    exc_valid = 1;
    cycle(); exc_valid = 0;
    cycle(); chk("midrst_in_mcause", 32'(csr_waddr), 32'h342);
    rst_n = 0;
    cycle(); chk("midrst_we", 32'(csr_we), 32'h0);
    chk("midrst_redir", 32'(redirect_valid), 32'h0);
    rst_n = 1;
    cycle(); chk("midrst_after", 32'(redirect_valid), 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst_n       = ($urandom_range(0, 99) != 0);
      exc_valid   = ($urandom_range(0, 9) == 0);
      irq_pending = ($urandom_range(0, 5) == 0);
      irq_enable  = $urandom_range(0, 1) == 1;
      mret_valid  = ($urandom_range(0, 7) == 0);
      exc_cause   = 5'($urandom);
      exc_tval    = $urandom;
      pc          = $urandom;
      mepc        = $urandom;
      mtvec       = $urandom;
      if ($urandom_range(0, 1) == 1) mtvec[1:0] = 2'b01;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
